comm_word_sequencer: RTL and testbench

COMM_WORD_SEQUENCER -- requirements
Module: comm_word_sequencer

---
 rtl/comm_pkg.sv | 19 +
 rtl/comm_word_fifo.sv | 72 +++++++
 rtl/comm_word_sequencer.sv | 138 +++++++++++++
 tb/tb_comm_word_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and defaults for the comm word sequencer and its word queue.
package comm_pkg;

    localparam int unsigned DEPTH_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } state_e;

    typedef struct packed {
        logic        sel;
        logic [31:0] data;
    } word_t;

endpackage

// File: rtl/comm_word_fifo.sv
// Word queue: DEPTH entries of {sel, data} with registered full/empty and a sticky overflow flag.
module comm_word_fifo
    import comm_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  word_t wr_word,
    input  logic  rd_en,
    output word_t rd_word,
    output logic  full,
    output logic  empty,
    output logic  overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    word_t           mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic            push, pop;

    // Acceptance looks only at the registered full flag, so a same-cycle pop never frees room.
    assign push = wr_en & ~full_q;
    assign pop  = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        count_d    = count_q + CW'(push) - CW'(pop);
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    assign rd_word  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/comm_word_sequencer.sv
// Sequencer: pops queued words, launches each to the comm stage and scores match/timeout results.
module comm_word_sequencer
    import comm_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        wr_sel,
    input  logic        start,
    input  logic        uart_data_match,
    input  logic        spi_data,
    input  logic [31:0] dataout,
    output logic [31:0] data,
    output logic        select,
    output logic        b,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic        done
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   data_q, data_d;
    logic          select_q, select_d;
    logic          b_q, b_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [7:0]    pass_q, pass_d;
    logic [7:0]    fail_q, fail_d;
    logic          pop, match, fifo_empty;
    word_t         head;

    comm_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_word  ({wr_sel, wr_data}),
        .rd_en    (pop),
        .rd_word  (head),
        .full     (full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign match = (dataout == data_q) && (select_q ? spi_data : uart_data_match);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        data_d   = data_q;
        select_d = select_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        b_d      = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: if (start && !fifo_empty) begin
                pop     = 1'b1;
                state_d = DRIVE;
            end
            DRIVE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A match takes priority over the timeout on the same cycle.
                if (match) begin
                    if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
                    state_d = NEXT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                    state_d = NEXT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            NEXT: if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = DRIVE;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            data_d   = head.data;
            select_d = head.sel;
            b_d      = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            data_q   <= '0;
            select_q <= 1'b0;
            b_q      <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            select_q <= select_d;
            b_q      <= b_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign data     = data_q;
    assign select   = select_q;
    assign b        = b_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign empty    = fifo_empty;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_comm_word_sequencer.sv
// Directed bench for comm_word_sequencer: a cycle vector table plus hand-written multi-cycle sequences.
module tb_comm_word_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, wr_en, wr_sel, start, uart_data_match, spi_data;
    logic [31:0] wr_data, dataout, data;
    logic        select, b, full, empty, busy, overflow, done;
    logic [7:0]  pass_cnt, fail_cnt;

    comm_word_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_sel(wr_sel),
        .start(start), .uart_data_match(uart_data_match), .spi_data(spi_data),
        .dataout(dataout), .data(data), .select(select), .b(b), .full(full),
        .empty(empty), .busy(busy), .overflow(overflow), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .done(done)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // {b, busy, done, empty, full, overflow, select, data, pass_cnt, fail_cnt}
    logic [54:0] obs;
    assign obs = {b, busy, done, empty, full, overflow, select, data, pass_cnt, fail_cnt};

    function automatic logic [54:0] pk(input logic b_, busy_, done_, empty_, full_, ovf_, sel_,
                                       input logic [31:0] d_, input logic [7:0] p_, f_);
        return {b_, busy_, done_, empty_, full_, ovf_, sel_, d_, p_, f_};
    endfunction

    typedef struct {
        logic        wr_en;
        logic [31:0] wr_data;
        logic        wr_sel;
        logic        start;
        logic        um;
        logic        spi;
        logic [31:0] dout;
        logic [54:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] exp_w [8];
    logic        exp_s [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        wr_en = 1'b0; wr_data = '0; wr_sel = 1'b0; start = 1'b0;
        uart_data_match = 1'b0; spi_data = 1'b0; dataout = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] w, input logic s);
        wr_en = 1'b1; wr_data = w; wr_sel = s;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Acts as the downstream stage: answers the first respond_n launches with a match.
    task automatic serve(input int unsigned respond_n, input int unsigned stop_at,
                         output int unsigned nb);
        nb = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (b) begin
                nb++;
                chk($sformatf("launch%0d_word", nb), {select, data}, {exp_s[nb-1], exp_w[nb-1]});
                if (nb <= respond_n) begin
                    dataout = exp_w[nb-1];
                    uart_data_match = ~exp_s[nb-1];
                    spi_data = exp_s[nb-1];
                end else begin
                    uart_data_match = 1'b0; spi_data = 1'b0;
                end
                if (nb == stop_at) return;
            end
            if (done) begin
                uart_data_match = 1'b0; spi_data = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_vec++; n_bad++;
        $display("FAIL serve_timeout: got no done, expected done within 2000 cycles");
    endtask

    task automatic timeout_run(input string name, input logic [31:0] w, input logic s,
                               input logic um, input logic spi);
        do_reset();
        wr(w, s);
        go();
        chk({name, "_b"}, {b, select, data}, {1'b1, s, w});
        dataout = w; uart_data_match = um; spi_data = spi;
        @(posedge clk); #1;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk({name, "_before"}, {busy, pass_cnt, fail_cnt}, {1'b1, 8'd0, 8'd0});
        @(posedge clk); #1;
        chk({name, "_fail"}, {busy, done, pass_cnt, fail_cnt}, {1'b1, 1'b0, 8'd0, 8'd1});
        @(posedge clk); #1;
        chk({name, "_done"}, {busy, done}, {1'b0, 1'b1});
        clr_inputs();
    endtask

    initial begin
        int unsigned nb;
        logic [31:0] a;
        a = 32'hA5A5_0001;
        //          wr   wdata          sel   start um    spi   dout
        vecs[0] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                    pk(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0)};
        vecs[1] = '{1'b1, a,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                    pk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0)};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                    pk(1, 1, 0, 1, 0, 0, 0, a, 0, 0)};
        vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                    pk(0, 1, 0, 1, 0, 0, 0, a, 0, 0)};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, a ^ 32'h1,
                    pk(0, 1, 0, 1, 0, 0, 0, a, 0, 0)};
        vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, a,
                    pk(0, 1, 0, 1, 0, 0, 0, a, 0, 0)};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, a,
                    pk(0, 1, 0, 1, 0, 0, 0, a, 1, 0)};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                    pk(0, 0, 1, 1, 0, 0, 0, a, 1, 0)};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                    pk(0, 0, 0, 1, 0, 0, 0, a, 1, 0)};

        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs, pk(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; wr_sel = vecs[i].wr_sel;
            start = vecs[i].start; uart_data_match = vecs[i].um; spi_data = vecs[i].spi;
            dataout = vecs[i].dout;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), obs, vecs[i].exp);
        end
        clr_inputs();

        timeout_run("spi_timeout", 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        timeout_run("uart_word_spi_flag", 32'hA5A5_0001, 1'b0, 1'b0, 1'b1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                exp_w[i] = 32'hC0DE_0000 + i;
                exp_s[i] = i[0];
            end
            wr(32'hC0DE_0000 + i, i[0]);
            if (i == 2) chk("fill3_not_full", {full, overflow}, 2'b00);
            if (i == 3) chk("fill4_full", {full, overflow}, 2'b10);
        end
        chk("fill5_overflow", {full, overflow, empty}, 3'b110);
        go();
        serve(4, 0, nb);
        chk("overflow_run_launches", nb, 4);
        chk("overflow_run_end", {pass_cnt, fail_cnt, overflow, full, empty, busy}, {8'd4, 8'd0, 4'b1010});

        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_w[i] = 32'h5EED_0010 + i;
            exp_s[i] = ~i[0];
            wr(exp_w[i], exp_s[i]);
        end
        go();
        serve(1, 2, nb);
        chk("midrun_second_launch", nb, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrun_reset", obs, pk(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        clr_inputs();
        exp_w[0] = 32'h0BAD_F00D;
        exp_s[0] = 1'b1;
        wr(exp_w[0], exp_s[0]);
        go();
        serve(1, 0, nb);
        chk("after_reset_launches", nb, 1);
        chk("after_reset_end", {pass_cnt, fail_cnt, empty, busy}, {8'd1, 8'd0, 2'b10});

        do_reset();
        for (int i = 0; i < 256; i++) begin
            exp_w[0] = 32'h0100_0000 + i;
            exp_s[0] = i[0];
            wr(exp_w[0], exp_s[0]);
            go();
            serve(1, 0, nb);
            if (i == 254) chk("pass_255", pass_cnt, 8'd255);
        end
        chk("pass_saturated", {pass_cnt, fail_cnt}, {8'd255, 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
